// File: rtl/cnn_relu_maxpool.sv
// cnn_relu_maxpool: ReLU followed by 2x2 stride-2 max pooling over a raster
// stream of conv output pixels. Every beat carries all CO channels at once.
// The channels share the col/row counters. Each channel keeps its own
// horizontal-pair register and half-width line buffer.
`timescale 1ns/1ps
`default_nettype none

module cnn_relu_maxpool #(
  parameter int CO     = 3,
  parameter int O_F_BW = 23,
  parameter int OW     = 24,
  parameter int OH     = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_in_valid,
  input  logic [CO*O_F_BW-1:0] i_in_fmap,
  output logic                 o_ot_valid,
  output logic [CO*O_F_BW-1:0] o_ot_fmap,
  output logic                 o_frame_done
);

  // Counter widths are never zero. The map is assumed to be at least 2x2.
  localparam int COL_W   = (OW > 1) ? $clog2(OW) : 1;
  localparam int ROW_W   = (OH > 1) ? $clog2(OH) : 1;
  localparam int LB_D    = OW / 2;
  localparam int LB_AW   = (LB_D > 1) ? $clog2(LB_D) : 1;
  // Pooling covers only the even-sized part of the map. An odd last
  // column or row is dropped.
  localparam int OW_EVEN = (OW / 2) * 2;
  localparam int OH_EVEN = (OH / 2) * 2;

  logic [COL_W-1:0]       col_q, col_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic                   ot_valid_q, ot_valid_d;
  logic                   frame_done_q, frame_done_d;
  logic [CO*O_F_BW-1:0]   ot_fmap_q, ot_fmap_d;

  logic                   last_col, last_row;
  logic                   col_odd, row_odd;
  logic                   pool_col, pool_row;
  logic                   h_we, lb_we, lb_re, out_fire, frame_end;
  logic [LB_AW-1:0]       lb_idx;

  // Position decode and the per-beat control strobes.
  always_comb begin
    last_col  = (col_q == COL_W'(OW - 1));
    last_row  = (row_q == ROW_W'(OH - 1));
    col_odd   = col_q[0];
    row_odd   = row_q[0];
    pool_col  = (32'(col_q) < OW_EVEN);
    pool_row  = (32'(row_q) < OH_EVEN);
    // Both columns of a pair map to the same buffer slot.
    lb_idx    = LB_AW'(col_q >> 1);
    h_we      = i_in_valid && !col_odd && pool_col;
    lb_we     = i_in_valid &&  col_odd && !row_odd && pool_col && pool_row;
    // In an odd row, fetch the upper pair on the even-column beat. The
    // registered read is then ready by the time the odd-column beat arrives.
    lb_re     = i_in_valid && !col_odd &&  row_odd && pool_col && pool_row;
    out_fire  = i_in_valid &&  col_odd &&  row_odd && pool_col && pool_row;
    frame_end = i_in_valid && last_col && last_row;
  end

  // Raster counters: advance only on valid beats, and wrap at the end of the frame.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (i_in_valid) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Output strobes are registered, so they pulse one cycle after the triggering beat.
  always_comb begin
    ot_valid_d   = out_fire;
    frame_done_d = frame_end;
  end

  genvar gi;
  generate
    for (gi = 0; gi < CO; gi++) begin : g_ch
      logic [O_F_BW-1:0] x_in;
      logic [O_F_BW-1:0] relu_v;
      logic [O_F_BW-1:0] h_q, h_d;
      logic [O_F_BW-1:0] pair_max;
      logic [O_F_BW-1:0] pool_max;
      logic [O_F_BW-1:0] lb_mem [LB_D];
      logic [O_F_BW-1:0] lb_rd_q;

      // ReLU. After this, every value is non-negative, so unsigned compares are exact.
      always_comb begin
        x_in     = i_in_fmap[gi*O_F_BW +: O_F_BW];
        relu_v   = x_in[O_F_BW-1] ? '0 : x_in;
        pair_max = (h_q > relu_v) ? h_q : relu_v;
        pool_max = (lb_rd_q > pair_max) ? lb_rd_q : pair_max;
      end

      // Left pixel of the current horizontal pair.
      always_comb begin
        h_d = h_q;
        if (h_we) h_d = relu_v;
      end

      // Horizontal pair register. It is cleared on reset.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) h_q <= '0;
        else       h_q <= h_d;
      end

      // Line buffer of pair maxima from the even row. No clear is needed:
      // each slot is written before it is read within the same frame.
      always_ff @(posedge clk) begin
        if (lb_we) lb_mem[lb_idx] <= pair_max;
      end

      // Registered read port of the line buffer.
      always_ff @(posedge clk) begin
        if (lb_re) lb_rd_q <= lb_mem[lb_idx];
      end

      // Load the pooled value on a window completion; otherwise hold the last value.
      assign ot_fmap_d[gi*O_F_BW +: O_F_BW] =
        out_fire ? pool_max : ot_fmap_q[gi*O_F_BW +: O_F_BW];
    end
  endgenerate

  // Control and output registers. A reset drops any partial frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      ot_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      ot_fmap_q    <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      ot_valid_q   <= ot_valid_d;
      frame_done_q <= frame_done_d;
      ot_fmap_q    <= ot_fmap_d;
    end
  end

  assign o_ot_valid   = ot_valid_q;
  assign o_ot_fmap    = ot_fmap_q;
  assign o_frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_cnn_relu_maxpool.sv
// Bench for cnn_relu_maxpool. Instance A: CO=3, 4x4, 8-bit. Instance B: CO=1, 5x5, 8-bit.
// A frame-array reference model predicts every cycle's outputs.
`timescale 1ns/1ps

module tb_cnn_relu_maxpool;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, a_ot_valid, a_done;
  logic [23:0] a_fmap, a_ot_fmap;
  logic        b_valid, b_ot_valid, b_done;
  logic [7:0]  b_fmap, b_ot_fmap;

  always #5 clk = ~clk;

  cnn_relu_maxpool #(.CO(3), .O_F_BW(8), .OW(4), .OH(4)) dut_a (
    .clk(clk), .reset(reset), .i_in_valid(a_valid), .i_in_fmap(a_fmap),
    .o_ot_valid(a_ot_valid), .o_ot_fmap(a_ot_fmap), .o_frame_done(a_done));

  cnn_relu_maxpool #(.CO(1), .O_F_BW(8), .OW(5), .OH(5)) dut_b (
    .clk(clk), .reset(reset), .i_in_valid(b_valid), .i_in_fmap(b_fmap),
    .o_ot_valid(b_ot_valid), .o_ot_fmap(b_ot_fmap), .o_frame_done(b_done));

  int tests = 0;
  int fails = 0;

  // Reference model: frame storage of ReLU'd pixels per instance.
  int          mr [2][25][3];
  int          mk [2];
  logic [23:0] mlast [2];

  // Observation logs.
  logic [23:0] a_pulses[$];
  int          a_pulse_beats[$];
  int          b_pulses[$];
  int          beat_a, beat_b, a_done_cnt, b_done_cnt, b_done_beat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int relu8(input logic [7:0] x);
    return x[7] ? 0 : int'(x);
  endfunction

  function automatic int max2(input int p, input int q);
    return (p > q) ? p : q;
  endfunction

  function automatic logic [23:0] ramp3(input int i);
    return {8'(i + 32), 8'(i + 16), 8'(i)};
  endfunction

  task automatic model_check(input int id, input logic v, input logic [23:0] d,
                             input logic ov, input logic [23:0] of, input logic od);
    int ow, nch, k, col, row, m;
    logic ev, ed;
    ow  = (id == 1) ? 5 : 4;
    nch = (id == 1) ? 1 : 3;
    ev  = 1'b0;
    ed  = 1'b0;
    if (v) begin
      k   = mk[id];
      col = k % ow;
      row = k / ow;
      for (int c = 0; c < nch; c++) mr[id][k][c] = relu8(d[c*8 +: 8]);
      if ((row % 2 == 1) && (col % 2 == 1) && (row < (ow/2)*2) && (col < (ow/2)*2)) begin
        ev = 1'b1;
        mlast[id] = '0;
        for (int c = 0; c < nch; c++) begin
          m = max2(max2(mr[id][k][c], mr[id][k-1][c]),
                   max2(mr[id][k-ow][c], mr[id][k-ow-1][c]));
          mlast[id][c*8 +: 8] = 8'(m);
        end
      end
      ed = (k == ow*ow - 1);
      mk[id] = (k + 1) % (ow*ow);
    end
    chk($sformatf("dut%0d_valid", id), 32'(ov), 32'(ev));
    chk($sformatf("dut%0d_fmap", id), 32'(of), 32'(mlast[id]));
    chk($sformatf("dut%0d_frame_done", id), 32'(od), 32'(ed));
  endtask

  // One clock cycle with the given inputs. The outputs are checked 1 time unit after the edge.
  task automatic cycle(input logic va, input logic [23:0] da, input logic vb, input logic [7:0] db);
    a_valid = va; a_fmap = da; b_valid = vb; b_fmap = db;
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    if (va) beat_a++;
    if (vb) beat_b++;
    if (a_ot_valid) begin a_pulses.push_back(a_ot_fmap); a_pulse_beats.push_back(beat_a); end
    if (b_ot_valid) b_pulses.push_back(int'(b_ot_fmap));
    if (a_done) a_done_cnt++;
    if (b_done) begin b_done_cnt++; b_done_beat = beat_b; end
    model_check(0, va, da, a_ot_valid, a_ot_fmap, a_done);
    model_check(1, vb, {16'b0, db}, b_ot_valid, {16'b0, b_ot_fmap}, b_done);
  endtask

  task automatic clear_logs();
    a_pulses.delete(); a_pulse_beats.delete(); b_pulses.delete();
    beat_a = 0; beat_b = 0; a_done_cnt = 0; b_done_cnt = 0; b_done_beat = -1;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_a_valid"}, 32'(a_ot_valid), 32'd0);
    chk({tag, "_a_fmap"},  32'(a_ot_fmap),  32'd0);
    chk({tag, "_a_done"},  32'(a_done),     32'd0);
    chk({tag, "_b_valid"}, 32'(b_ot_valid), 32'd0);
    chk({tag, "_b_fmap"},  32'(b_ot_fmap),  32'd0);
    chk({tag, "_b_done"},  32'(b_done),     32'd0);
  endtask

  // Asynchronous reset is asserted mid-cycle and released away from the clock edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1 check_zero_outputs("async_reset");
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    check_zero_outputs("held_reset");
    #2 reset = 1'b0;
    mk[0] = 0; mk[1] = 0; mlast[0] = '0; mlast[1] = '0;
    clear_logs();
  endtask

  task automatic check_ch0_ramp(input string tag, input int base);
    int ev[4] = '{5, 7, 13, 15};
    chk({tag, "_count"}, 32'(a_pulses.size()), 32'd4);
    for (int i = 0; i < 4 && i < a_pulses.size(); i++)
      chk($sformatf("%s_val%0d", tag, i), 32'(a_pulses[i][7:0]), 32'(ev[i] + base));
  endtask

  initial begin
    logic [7:0] win[16];
    int         rv[6];
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_fmap = '0; b_fmap = '0;
    mk[0] = 0; mk[1] = 0; mlast[0] = '0; mlast[1] = '0;
    clear_logs();
    repeat (2) @(posedge clk);
    #1 check_zero_outputs("reset_state");
    #2 reset = 1'b0;

    // Ramp 0..15 on A (channel c offset by 16*c) alongside ramp 0..24 on B.
    for (int i = 0; i < 25; i++) cycle(i < 16, ramp3(i), 1'b1, 8'(i));
    check_ch0_ramp("ramp", 0);
    chk("ramp_done_cnt", 32'(a_done_cnt), 32'd1);
    chk("ramp_done_with_last", 32'(a_pulse_beats.size() == 4 ? a_pulse_beats[3] : -1), 32'd16);
    chk("odd_count", 32'(b_pulses.size()), 32'd4);
    rv = '{6, 8, 16, 18, 0, 0};
    for (int i = 0; i < 4 && i < b_pulses.size(); i++)
      chk($sformatf("odd_val%0d", i), 32'(b_pulses[i]), 32'(rv[i]));
    chk("odd_done_beat", 32'(b_done_beat), 32'd25);
    clear_logs();

    // All inputs equal to -3 give zeros. Then a window mixing negatives with a small positive.
    for (int i = 0; i < 16; i++) cycle(1'b1, 24'hFDFDFD, 1'b0, 8'h00);
    chk("neg_count", 32'(a_pulses.size()), 32'd4);
    for (int i = 0; i < a_pulses.size(); i++) chk($sformatf("neg_val%0d", i), 32'(a_pulses[i]), 32'd0);
    clear_logs();
    for (int i = 0; i < 16; i++) win[i] = 8'($urandom);
    win[0] = 8'h9C; win[1] = 8'hFF; win[4] = 8'hCE; win[5] = 8'h02;
    for (int i = 0; i < 16; i++) cycle(1'b1, {8'($urandom), 8'($urandom), win[i]}, 1'b0, 8'h00);
    chk("window_first", 32'(a_pulses.size() > 0 ? a_pulses[0][7:0] : 8'hEE), 32'd2);
    clear_logs();

    // Ramp with valid pattern 1,0,0: pulses follow accepted beats 6, 8, 14 and 16.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, ramp3(i), 1'b0, 8'h00);
      cycle(1'b0, 24'hABCDEF, 1'b0, 8'h00);
      cycle(1'b0, 24'h123456, 1'b0, 8'h00);
    end
    check_ch0_ramp("gap", 0);
    rv = '{6, 8, 14, 16, 0, 0};
    for (int i = 0; i < 4 && i < a_pulse_beats.size(); i++)
      chk($sformatf("gap_beat%0d", i), 32'(a_pulse_beats[i]), 32'(rv[i]));

    // Five beats, then a sixth beat that coincides with reset and is dropped. Then a full ramp.
    clear_logs();
    for (int i = 0; i < 5; i++) cycle(1'b1, ramp3(i), 1'b1, 8'(i));
    a_valid = 1'b1; a_fmap = ramp3(5);
    chk("pre_reset_pulses", 32'(a_pulses.size()), 32'd0);
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, ramp3(i), 1'b0, 8'h00);
    check_ch0_ramp("post_reset", 0);

    // Two back-to-back frames on all three channels.
    clear_logs();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 16; i++) cycle(1'b1, ramp3(i), 1'b0, 8'h00);
    chk("b2b_count", 32'(a_pulses.size()), 32'd8);
    chk("b2b_done_cnt", 32'(a_done_cnt), 32'd2);
    rv = '{5, 7, 13, 15, 0, 0};
    for (int i = 0; i < a_pulses.size(); i++)
      for (int c = 0; c < 3; c++)
        chk($sformatf("b2b_p%0d_ch%0d", i, c), 32'(a_pulses[i][c*8 +: 8]), 32'(rv[i % 4] + 16*c));

    // Random data and random valid on both instances. The model checks every cycle.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 9) < 7, 24'($urandom), $urandom_range(0, 9) < 6, 8'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
